// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of a register file: buffers up to DEPTH
// pending writes, drains one per unstalled cycle, and forwards pending data to reads.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wb_stall,
  output logic                     write_en,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        read_addr,
  input  logic [DATA_W-1:0]        rf_read_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     bypass_hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, not_empty;
  logic [PTR_W-1:0] scan_idx;

  // Handshake depends only on registered occupancy, never on wb_stall/in_valid.
  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != FULL);
  assign push      = in_valid && in_ready;
  assign write_en  = not_empty && !wb_stall;
  assign pop       = write_en;

  assign write_addr = not_empty ? addr_q[rd_ptr_q] : '0;
  assign write_data = not_empty ? data_q[rd_ptr_q] : '0;
  assign count      = count_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    read_data  = rf_read_data;
    bypass_hit = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[scan_idx] == read_addr)) begin
        read_data  = data_q[scan_idx];
        bypass_hit = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q gates every use
  // of it, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue: per-cycle vector table
// followed by streaming-wrap and mid-operation reset sequences.
module tb_regfile_wb_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr;
  logic [31:0] rf_read_data;
  logic [31:0] read_data;
  logic        bypass_hit;
  logic [2:0]  count;

  int checks_total;
  int checks_passed;

  regfile_wb_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .wb_stall     (wb_stall),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_addr    (read_addr),
    .rf_read_data (rf_read_data),
    .read_data    (read_data),
    .bypass_hit   (bypass_hit),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in register file: a fixed, address-dependent pattern.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return 32'hA000_0000 | {27'd0, a};
  endfunction

  assign rf_read_data = rf_val(read_addr);

  typedef struct {
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wb_stall;
    logic [4:0]  read_addr;
    logic [2:0]  exp_count;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      checks_passed++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    wb_stall  = 1'b0;
    read_addr = '0;

    //                in_v  addr    data           stall ra     cnt   rdy  we   waddr  wdata          rdata              hit
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  3'd0, 1'b1, 1'b0, 5'd0,  32'h0,        rf_val(5'd0),  1'b0};
    vecs[1]  = '{1'b1, 5'd0,  32'hffff,     1'b0, 5'd0,  3'd0, 1'b1, 1'b0, 5'd0,  32'h0,        rf_val(5'd0),  1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  3'd1, 1'b1, 1'b1, 5'd0,  32'hffff,     32'hffff,      1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  3'd0, 1'b1, 1'b0, 5'd0,  32'h0,        rf_val(5'd0),  1'b0};
    vecs[4]  = '{1'b1, 5'd2,  32'hfffc,     1'b1, 5'd2,  3'd0, 1'b1, 1'b0, 5'd0,  32'h0,        rf_val(5'd2),  1'b0};
    vecs[5]  = '{1'b1, 5'd31, 32'hfff0,     1'b1, 5'd2,  3'd1, 1'b1, 1'b0, 5'd2,  32'hfffc,     32'hfffc,      1'b1};
    vecs[6]  = '{1'b1, 5'd2,  32'h1234,     1'b1, 5'd2,  3'd2, 1'b1, 1'b0, 5'd2,  32'hfffc,     32'hfffc,      1'b1};
    vecs[7]  = '{1'b1, 5'd5,  32'h5,        1'b1, 5'd2,  3'd3, 1'b1, 1'b0, 5'd2,  32'hfffc,     32'h1234,      1'b1};
    vecs[8]  = '{1'b1, 5'd9,  32'h9999,     1'b1, 5'd7,  3'd4, 1'b0, 1'b0, 5'd2,  32'hfffc,     rf_val(5'd7),  1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  3'd4, 1'b0, 1'b0, 5'd2,  32'hfffc,     rf_val(5'd9),  1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd2,  3'd4, 1'b0, 1'b1, 5'd2,  32'hfffc,     32'h1234,      1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 3'd3, 1'b1, 1'b1, 5'd31, 32'hfff0,     32'hfff0,      1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd2,  3'd2, 1'b1, 1'b1, 5'd2,  32'h1234,     32'h1234,      1'b1};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  3'd1, 1'b1, 1'b1, 5'd5,  32'h5,        32'h5,         1'b1};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  3'd0, 1'b1, 1'b0, 5'd0,  32'h0,        rf_val(5'd5),  1'b0};

    // Reset state, observed before any clock edge.
    #2;
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_we", write_en, 0);
    check("rst_waddr", write_addr, 0);
    check("rst_wdata", write_data, 0);
    check("rst_hit", bypass_hit, 0);
    check("rst_rdata", read_data, rf_val(5'd0));

    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Cycle-by-cycle vectors: outputs checked before the edge that applies them.
    for (int i = 0; i < 15; i++) begin
      in_valid  = vecs[i].in_valid;
      in_addr   = vecs[i].in_addr;
      in_data   = vecs[i].in_data;
      wb_stall  = vecs[i].wb_stall;
      read_addr = vecs[i].read_addr;
      #1;
      check($sformatf("v%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_we", i), write_en, vecs[i].exp_we);
      check($sformatf("v%0d_waddr", i), write_addr, vecs[i].exp_waddr);
      check($sformatf("v%0d_wdata", i), write_data, vecs[i].exp_wdata);
      check($sformatf("v%0d_rdata", i), read_data, vecs[i].exp_rdata);
      check($sformatf("v%0d_hit", i), bypass_hit, vecs[i].exp_hit);
      next_cycle();
    end

    // Streaming across pointer wrap: fill under stall, then hold in_valid.
    // Item k has addr (3k)%32 and data C0DE_0000+k.
    wb_stall  = 1'b1;
    read_addr = 5'd30;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_addr  = 5'((k * 3) % 32);
      in_data  = 32'hC0DE_0000 + 32'(k);
      next_cycle();
    end
    wb_stall = 1'b0;
    for (int c = 0; c < 14; c++) begin
      // Item 4 is presented at c=0 while full (ignored) and accepted at c=1.
      in_valid = (c < 11);
      in_addr  = 5'(((c == 0 ? 4 : c + 3) * 3) % 32);
      in_data  = 32'hC0DE_0000 + 32'(c == 0 ? 4 : c + 3);
      #1;
      check($sformatf("s%0d_count", c), count, (c == 0) ? 4 : ((c <= 11) ? 3 : 14 - c));
      check($sformatf("s%0d_ready", c), in_ready, (c != 0));
      check($sformatf("s%0d_we", c), write_en, 1);
      check($sformatf("s%0d_waddr", c), write_addr, (c * 3) % 32);
      check($sformatf("s%0d_wdata", c), write_data, 32'hC0DE_0000 + 32'(c));
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    check("s_end_count", count, 0);
    check("s_end_we", write_en, 0);

    // Reset dropped between edges with three writes pending under stall.
    next_cycle();
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_addr  = 5'd20 + 5'(k);
      in_data  = 32'hBEEF_0000 + 32'(k);
      next_cycle();
    end
    in_valid  = 1'b0;
    read_addr = 5'd21;
    #1;
    check("mr_pre_count", count, 3);
    check("mr_pre_hit", bypass_hit, 1);
    #1;
    rst_n    = 1'b0;
    wb_stall = 1'b0;
    #1;
    check("mr_count", count, 0);
    check("mr_we", write_en, 0);
    check("mr_ready", in_ready, 1);
    check("mr_waddr", write_addr, 0);
    check("mr_hit", bypass_hit, 0);
    check("mr_rdata", read_data, rf_val(5'd21));
    next_cycle();
    check("mr_hold_we", write_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mr_post%0d_we", c), write_en, 0);
      check($sformatf("mr_post%0d_count", c), count, 0);
      next_cycle();
    end

    // First request after reset is accepted and written back on the next cycle.
    in_valid = 1'b1;
    in_addr  = 5'd7;
    in_data  = 32'h77;
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("rs_we", write_en, 1);
    check("rs_waddr", write_addr, 7);
    check("rs_wdata", write_data, 32'h77);
    next_cycle();
    check("rs_count", count, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
